regfile_sb: RTL

Parametrised 3-read / 1-write register file, the successor to the fixed 32x32 CPU register file. Adds:
- a hardware clear sequencer that zeroes every entry after reset or on request;
- a per-register pending scoreboard for pipeline hazard detection;
- configurable width and depth.

It sits between decode (two read ports plus the scoreboard query) and write-back (write port). A third read port is the debug/test port for the board display.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 45 ++++
 rtl/regfile_sb.sv | 116 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file with clear sequencer and scoreboard.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per register: set by a newly issued producer, cleared by its write-back.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] q_addr1,
    input  logic [ADDR_W-1:0] q_addr2,
    output logic              pend1,
    output logic              pend2
);

    localparam int DEPTH = depth(ADDR_W);

    logic [DEPTH-1:0] bits;
    logic [DEPTH-1:0] bits_nxt;

    // Clear is applied before set so a same-address set wins: the new producer is still outstanding.
    always_comb begin
        bits_nxt = bits;
        if (clr)
            bits_nxt[clr_addr] = 1'b0;
        if (set && !(ZERO_REG && set_addr == '0))
            bits_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush)
            bits <= '0;
        else
            bits <= bits_nxt;
    end

    assign pend1 = bits[q_addr1];
    assign pend2 = bits[q_addr2];

endmodule

// File: rtl/regfile_sb.sv
// 3-read/1-write register file with hardware clear sequencer and pending scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_WR_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] test_addr,
    output logic [DATA_W-1:0] test_data,
    input  logic              clr_req,
    output logic              busy,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              pend1,
    output logic              pend2
);

    localparam int DEPTH = depth(ADDR_W);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic idle;
    logic take;
    logic wr_ok;
    logic sb_pend1;
    logic sb_pend2;

    assign idle  = resetn && (state == ST_IDLE);
    // A clear request in the same cycle swallows any write or pending-set.
    assign take  = idle && !clr_req;
    assign wr_ok = take && wen && !(ZERO_REG && waddr == '0);
    assign busy  = !resetn || (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1))
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && state == ST_CLEAR)
            mem[cnt] <= '0;
        else if (wr_ok)
            mem[waddr] <= wdata;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a,
                                                    input logic [DATA_W-1:0] stored);
        if (!idle || (ZERO_REG && a == '0))
            return '0;
`ifdef REGFILE_WR_BYPASS_EN
        if (wr_ok && waddr == a)
            return wdata;
`endif
        return stored;
    endfunction

    assign rdata1    = read_port(raddr1, mem[raddr1]);
    assign rdata2    = read_port(raddr2, mem[raddr2]);
    assign test_data = read_port(test_addr, mem[test_addr]);

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .resetn   (resetn),
        .flush    ((state == ST_CLEAR) || (idle && clr_req)),
        .set      (take && pend_set),
        .set_addr (pend_addr),
        .clr      (take && wen),
        .clr_addr (waddr),
        .q_addr1  (raddr1),
        .q_addr2  (raddr2),
        .pend1    (sb_pend1),
        .pend2    (sb_pend2)
    );

`ifdef REGFILE_WR_BYPASS_EN
    assign pend1 = idle && sb_pend1 && !(wr_ok && waddr == raddr1);
    assign pend2 = idle && sb_pend2 && !(wr_ok && waddr == raddr2);
`else
    assign pend1 = idle && sb_pend1;
    assign pend2 = idle && sb_pend2;
`endif

endmodule
